// File: rtl/pipe_scoreboard_if.sv
// Decode-side bundle of the pipeline scoreboard: issue fields in, hazard/forward/write-back out.
// The scoreboard itself sits on the slave modport; the decode/control side drives the master.
interface pipe_scoreboard_if #(
    parameter int GPR_NUM = 32,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 32
);
    localparam int ADDR_W = $clog2(GPR_NUM);
    localparam int FWD_W  = $clog2(DEPTH + 1);

    logic              cpu_en;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs0_addr;
    logic [ADDR_W-1:0] id_rs1_addr;
    logic              id_rs0_used;
    logic              id_rs1_used;
    logic              id_gpr_we_;
    logic [ADDR_W-1:0] id_dst_addr;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic [FWD_W-1:0]  fwd_sel_0;
    logic [FWD_W-1:0]  fwd_sel_1;
    logic              wb_gpr_we_;
    logic [ADDR_W-1:0] wb_dst_addr;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output cpu_en, id_valid, id_rs0_addr, id_rs1_addr, id_rs0_used, id_rs1_used,
               id_gpr_we_, id_dst_addr, id_is_load, flush,
        input  stall, fwd_sel_0, fwd_sel_1, wb_gpr_we_, wb_dst_addr, stall_cnt
    );

    modport slave (
        input  cpu_en, id_valid, id_rs0_addr, id_rs1_addr, id_rs0_used, id_rs1_used,
               id_gpr_we_, id_dst_addr, id_is_load, flush,
        output stall, fwd_sel_0, fwd_sel_1, wb_gpr_we_, wb_dst_addr, stall_cnt
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Pipeline register scoreboard: tracks in-flight writers, selects forwarding sources and
// stalls decode on not-yet-ready load results. Stage 1 = EX register, stage DEPTH = write-back.
module pipe_scoreboard #(
    parameter int GPR_NUM    = 32,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_scoreboard_if.slave  sb
);
    localparam int ADDR_W = $clog2(GPR_NUM);
    localparam int FWD_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic              we_;
        logic [ADDR_W-1:0] dst;
        logic              is_load;
    } entry_t;

    localparam entry_t BUBBLE = '{valid: 1'b0, we_: 1'b1, dst: '0, is_load: 1'b0};

    entry_t            stg [1:DEPTH];
    entry_t            stage1_next;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              stall;

    logic [ADDR_W-1:0] rs_addr [2];
    logic              rs_used [2];
    logic [FWD_W-1:0]  fwd_sel [2];
    logic              hit     [2];
    logic              rdy     [2];

    assign rs_addr[0] = sb.id_rs0_addr;
    assign rs_addr[1] = sb.id_rs1_addr;
    assign rs_used[0] = sb.id_rs0_used;
    assign rs_used[1] = sb.id_rs1_used;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            fwd_sel[n] = '0;
            hit[n]     = 1'b0;
            rdy[n]     = 1'b1;
            for (int k = DEPTH; k >= 1; k--) begin
                if (stg[k].valid && !stg[k].we_ && rs_used[n] &&
                    stg[k].dst == rs_addr[n] && stg[k].dst != '0) begin
                    fwd_sel[n] = FWD_W'(k);
                    hit[n]     = 1'b1;
                    rdy[n]     = !stg[k].is_load || (k >= LOAD_READY);
                end
            end
        end
    end

    always_comb begin
        stall = sb.id_valid && !sb.flush &&
                ((hit[0] && !rdy[0]) || (hit[1] && !rdy[1]));
    end

    always_comb begin
        stage1_next = BUBBLE;
        if (sb.id_valid && !stall && !sb.flush) begin
            stage1_next.valid   = 1'b1;
            stage1_next.we_     = sb.id_gpr_we_;
            stage1_next.dst     = sb.id_dst_addr;
            stage1_next.is_load = sb.id_is_load;
        end
    end

    // A flush kills both the decode instruction and the current stage-1 entry, so the
    // stage-1 occupant becomes a bubble as it moves into stage 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stg[k] <= BUBBLE;
            end
            stall_cnt_q <= '0;
        end else if (sb.cpu_en) begin
            stg[1] <= stage1_next;
            for (int k = 2; k <= DEPTH; k++) begin
                stg[k] <= (k == 2 && sb.flush) ? BUBBLE : stg[k-1];
            end
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sb.stall       = stall;
    assign sb.fwd_sel_0   = fwd_sel[0];
    assign sb.fwd_sel_1   = fwd_sel[1];
    assign sb.wb_gpr_we_  = !(stg[DEPTH].valid && !stg[DEPTH].we_);
    assign sb.wb_dst_addr = stg[DEPTH].dst;
    assign sb.stall_cnt   = stall_cnt_q;
endmodule
